// File: rtl/gb_rank_scan.sv
// gb_rank_scan: post-frame scan of the gray-level "seen" bitmap.
// Walks every bitmap address once, writes each level's rank (number of
// occupied levels strictly below it) into the remap LUT, and clears the
// bitmap entry so the statistics stage starts the next frame empty.
// The final occupied-level count is reported on `levels`.
//
// Optional build macro GB_RANK_SCAN_CHECK_EN adds the cnt_mismatch output,
// comparing the scanned level count with the statistics block's own count.
module gb_rank_scan #(
  parameter int DATA_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  din_sop,
  input  logic [DATA_WIDTH:0]   stat_cnt,
  output logic [DATA_WIDTH-1:0] bm_rd_addr,
  input  logic                  bm_rd_q,
  output logic [DATA_WIDTH-1:0] bm_wr_addr,
  output logic                  bm_clr_we,
  output logic [DATA_WIDTH-1:0] lut_addr,
  output logic [DATA_WIDTH-1:0] lut_data,
  output logic                  lut_we,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH:0]   levels,
  output logic                  overrun
`ifdef GB_RANK_SCAN_CHECK_EN
  ,
  output logic                  cnt_mismatch
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [DATA_WIDTH-1:0] LAST_ADDR = {DATA_WIDTH{1'b1}};

  state_t                state_reg;
  logic [DATA_WIDTH-1:0] rd_addr_reg;
  logic                  busy_reg;
  logic                  done_reg;

  // Read data lags the issued address by one cycle, so the write side runs
  // one cycle behind the read side.
  logic                  valid_d1;
  logic [DATA_WIDTH-1:0] addr_d1;

  // Rank is one bit wider than an address so a fully occupied bitmap
  // ends at 2^DATA_WIDTH instead of wrapping to zero.
  logic [DATA_WIDTH:0]   rank_reg;
  logic [DATA_WIDTH:0]   levels_reg;
  logic                  overrun_reg;

  logic                  start_accept;

  assign start_accept = (state_reg == ST_IDLE) && start;

  // Scan sequencer: one address per cycle, then a drain cycle for the last
  // read to land, then a single done cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      rd_addr_reg <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          done_reg <= 1'b0;
          if (start) begin
            state_reg   <= ST_SCAN;
            rd_addr_reg <= '0;
            busy_reg    <= 1'b1;
          end
        end
        ST_SCAN: begin
          if (rd_addr_reg == LAST_ADDR) begin
            // Read address parks at 0 whenever no scan is issuing reads.
            state_reg   <= ST_DRAIN;
            rd_addr_reg <= '0;
          end else begin
            rd_addr_reg <= rd_addr_reg + 1'b1;
          end
        end
        ST_DRAIN: begin
          state_reg <= ST_DONE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b1;
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
          done_reg  <= 1'b0;
        end
        default: begin
          state_reg   <= ST_IDLE;
          rd_addr_reg <= '0;
          busy_reg    <= 1'b0;
          done_reg    <= 1'b0;
        end
      endcase
    end
  end

  // Delay the issued address by the bitmap read latency; address holds
  // its last value when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_d1 <= 1'b0;
      addr_d1  <= '0;
    end else begin
      valid_d1 <= (state_reg == ST_SCAN);
      if (state_reg == ST_SCAN) begin
        addr_d1 <= rd_addr_reg;
      end
    end
  end

  // Running rank: the LUT entry uses the count before this level's bit is
  // added, giving "occupied levels strictly below".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rank_reg <= '0;
    end else if (start_accept) begin
      rank_reg <= '0;
    end else if (valid_d1) begin
      rank_reg <= rank_reg + {{DATA_WIDTH{1'b0}}, bm_rd_q};
    end
  end

  // Capture the final count in the done cycle; held until the next scan ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      levels_reg <= '0;
    end else if (state_reg == ST_DONE) begin
      levels_reg <= rank_reg;
    end
  end

  // Sticky flag: a new video packet arrived while the scan owned the bitmap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_reg <= 1'b0;
    end else if (din_sop && busy_reg) begin
      overrun_reg <= 1'b1;
    end
  end

  // Write side: LUT write and bitmap clear share the delayed address.
  assign lut_we     = valid_d1;
  assign lut_addr   = addr_d1;
  assign bm_clr_we  = valid_d1;
  assign bm_wr_addr = addr_d1;
  // An inconsistent bitmap could push rank past the LUT range; clamp it.
  assign lut_data   = rank_reg[DATA_WIDTH] ? {DATA_WIDTH{1'b1}}
                                           : rank_reg[DATA_WIDTH-1:0];

  assign bm_rd_addr = rd_addr_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign levels     = levels_reg;
  assign overrun    = overrun_reg;

`ifdef GB_RANK_SCAN_CHECK_EN
  logic [DATA_WIDTH:0] stat_cnt_reg;
  logic                cnt_mismatch_reg;

  // The statistics count is latched with the accepted start so later
  // changes on stat_cnt cannot affect this scan's comparison.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_cnt_reg <= '0;
    end else if (start_accept) begin
      stat_cnt_reg <= stat_cnt;
    end
  end

  // Compare scanned and reported counts once per completed scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_mismatch_reg <= 1'b0;
    end else if (state_reg == ST_DONE) begin
      cnt_mismatch_reg <= (rank_reg != stat_cnt_reg);
    end
  end

  assign cnt_mismatch = cnt_mismatch_reg;
`else
  // stat_cnt only feeds the optional count check.
  logic unused_stat_cnt;
  assign unused_stat_cnt = ^stat_cnt;
`endif

endmodule
